// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit and its memory port.
package lsu_pkg;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } memory_access_width_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    SPLIT  = 2'b10,
    RESP   = 2'b11
  } lsu_state_t;

  function automatic logic [2:0] width_bytes(memory_access_width_t w);
    case (w)
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

  function automatic logic is_aligned(memory_access_width_t w, logic [1:0] lo);
    case (w)
      MEM_BYTE: return 1'b1;
      MEM_HALF: return ~lo[0];
      default:  return (lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/memory_port.sv
// Single-cycle memory port: data_rd is returned combinationally while valid is high.
interface memory_port;
  import lsu_pkg::*;

  logic                 valid;
  logic                 we;
  logic [ADDR_W-1:0]    addr;
  memory_access_width_t width;
  logic [WORD_W-1:0]    data_wr;
  logic [WORD_W-1:0]    data_rd;

  modport datapath (output valid, output we, output addr, output width,
                    output data_wr, input data_rd);
  modport memory   (input valid, input we, input addr, input width,
                    input data_wr, output data_rd);
endinterface

// File: rtl/lsu_extend.sv
// Sign or zero extension of right-justified load data to a full word.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0]    data_i,
  input  memory_access_width_t width_i,
  input  logic                 unsigned_i,
  output logic [WORD_W-1:0]    data_o
);

  always_comb begin
    data_o = data_i;
    case (width_i)
      MEM_BYTE: data_o = {{(WORD_W-8){~unsigned_i & data_i[7]}}, data_i[7:0]};
      MEM_HALF: data_o = {{(WORD_W-16){~unsigned_i & data_i[15]}}, data_i[15:0]};
      default:  data_o = data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: aligned accesses go out in one cycle, misaligned ones are
// either split into byte accesses or rejected, depending on SPLIT_MISALIGNED.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  memory_access_width_t req_width,
  input  logic                 req_unsigned,
  input  logic [WORD_W-1:0]    req_wdata,
  output logic                 resp_valid,
  output logic [WORD_W-1:0]    resp_rdata,
  output logic                 resp_error,
  output lsu_state_t           dbg_state,
  memory_port.datapath         mem
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // the response side is a one-cycle resp_valid pulse with no back-pressure.

  lsu_state_t           state_q;
  logic [1:0]           cnt_q;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  memory_access_width_t width_q;
  logic                 uns_q;
  logic [WORD_W-1:0]    wdata_q;
  logic [WORD_W-1:0]    buf_q;
  logic                 err_q;

  logic [1:0]           last_cnt;
  logic [WORD_W-1:0]    ext_data;
  logic                 resp_active;

  assign last_cnt    = 2'(width_bytes(width_q) - 3'd1);
  assign resp_active = (state_q == RESP) && !rst;
  assign req_ready   = (state_q == IDLE) && !rst;
  assign resp_valid  = resp_active;
  assign resp_error  = resp_active && err_q;
  assign dbg_state   = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      width_q <= MEM_BYTE;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            width_q <= req_width;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            buf_q   <= '0;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
            if (is_aligned(req_width, req_addr[1:0])) begin
              state_q <= ACCESS;
            end else if (SPLIT_MISALIGNED) begin
              state_q <= SPLIT;
            end else begin
              err_q   <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        ACCESS: begin
          buf_q   <= mem.data_rd;
          state_q <= RESP;
        end
        SPLIT: begin
          // Byte cnt of the access lands in byte lane cnt of the buffer.
          buf_q[{cnt_q, 3'b000} +: 8] <= mem.data_rd[7:0];
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == last_cnt) state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem.valid   = 1'b0;
    mem.we      = 1'b0;
    mem.addr    = '0;
    mem.width   = MEM_BYTE;
    mem.data_wr = '0;
    if (!rst) begin
      case (state_q)
        ACCESS: begin
          mem.valid   = 1'b1;
          mem.we      = we_q;
          mem.addr    = addr_q;
          mem.width   = width_q;
          mem.data_wr = wdata_q;
        end
        SPLIT: begin
          mem.valid   = 1'b1;
          mem.we      = we_q;
          mem.addr    = addr_q + {{(ADDR_W-2){1'b0}}, cnt_q};
          mem.width   = MEM_BYTE;
          mem.data_wr = {{(WORD_W-8){1'b0}}, wdata_q[{cnt_q, 3'b000} +: 8]};
        end
        default: ;
      endcase
    end
  end

  lsu_extend u_extend (
    .data_i     (buf_q),
    .width_i    (width_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  assign resp_rdata = (resp_active && !we_q && !err_q) ? ext_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one splitting instance, one rejecting instance.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 sel;
  logic                 req_valid;
  logic                 req_we;
  logic [31:0]          req_addr;
  memory_access_width_t req_width;
  logic                 req_unsigned;
  logic [31:0]          req_wdata;

  logic        rdy0, rdy1, rv0, rv1, err0, err1;
  logic [31:0] rd0, rd1;
  lsu_state_t  st0, st1;

  memory_port m0();
  memory_port m1();

  load_store_unit #(.SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rdy0),
    .req_we(req_we), .req_addr(req_addr), .req_width(req_width),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .resp_valid(rv0),
    .resp_rdata(rd0), .resp_error(err0), .dbg_state(st0), .mem(m0)
  );

  load_store_unit #(.SPLIT_MISALIGNED(1'b0)) dut_rej (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rdy1),
    .req_we(req_we), .req_addr(req_addr), .req_width(req_width),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .resp_valid(rv1),
    .resp_rdata(rd1), .resp_error(err1), .dbg_state(st1), .mem(m1)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // byte memory model for dut; upper read bytes are real neighbours, not zero
  logic [7:0] mb [256];
  logic [7:0] ma;
  assign ma = m0.addr[7:0];
  assign m0.data_rd = {mb[8'(ma + 8'd3)], mb[8'(ma + 8'd2)], mb[8'(ma + 8'd1)], mb[ma]};
  assign m1.data_rd = 32'h1234_5678;

  always @(posedge clk) begin
    if (m0.valid && m0.we) begin
      mb[ma] = m0.data_wr[7:0];
      if (m0.width != MEM_BYTE) mb[8'(ma + 8'd1)] = m0.data_wr[15:8];
      if (m0.width == MEM_WORD) begin
        mb[8'(ma + 8'd2)] = m0.data_wr[23:16];
        mb[8'(ma + 8'd3)] = m0.data_wr[31:24];
      end
    end
  end

  // transaction monitor
  int          log_cyc[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [31:0] log_info[$];
  int          rej_mem_cnt = 0;
  int          bad_we_cnt = 0;
  always @(negedge clk) begin
    if (m0.valid) begin
      log_cyc.push_back(cyc);
      log_addr.push_back(m0.addr);
      log_data.push_back(m0.data_wr);
      log_info.push_back({29'd0, m0.we, m0.width});
    end
    if (m1.valid) rej_mem_cnt++;
    if ((!m0.valid && m0.we) || (!m1.valid && m1.we)) bad_we_cnt++;
  end

  // scoreboard
  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_a[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic clear_log();
    log_cyc.delete(); log_addr.delete(); log_data.delete(); log_info.delete();
  endtask

  task automatic check_log(input string tag, input int n_acc, input logic we,
                           input memory_access_width_t w);
    check({tag, "_nacc"}, log_addr.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < log_addr.size(); i++) begin
      check({tag, "_addr"}, log_addr[i], exp_a[i]);
      check({tag, "_cyc"}, log_cyc[i] - n_acc, i + 1);
      check({tag, "_we_w"}, log_info[i], {29'd0, we, w});
      if (we) check({tag, "_wdata"}, log_data[i], exp_q[i]);
    end
    exp_a.delete(); exp_q.delete();
  endtask

  // driver: present one request, wait for its response (bounded)
  task automatic run_req(input logic s, input logic we, input logic [31:0] addr,
                         input memory_access_width_t w, input logic uns,
                         input logic [31:0] wdata, output int n_acc, output int lat,
                         output logic [31:0] rdata, output logic err);
    @(negedge clk);
    check("ready_idle", s ? rdy1 : rdy0, 1'b1);
    clear_log();
    n_acc = cyc;
    sel = s; req_we = we; req_addr = addr; req_width = w;
    req_unsigned = uns; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 99; rdata = 32'hDEAD_BEEF; err = 1'bx;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s ? rv1 : rv0) begin
        lat = cyc - n_acc;
        rdata = s ? rd1 : rd0;
        err = s ? err1 : err0;
        check("ready_in_resp", s ? rdy1 : rdy0, 1'b0);
        break;
      end
    end
  endtask

  int n, lat;
  logic [31:0] rdata;
  logic err;

  initial begin
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_width = MEM_BYTE; req_unsigned = 1'b0; req_wdata = '0;
    for (int i = 0; i < 256; i++) mb[i] = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", rdy0, 1'b0);
    check("rst_resp_valid", rv0, 1'b0);
    check("rst_resp_error", err0, 1'b0);
    check("rst_rdata", rd0, 32'h0);
    check("rst_mem_valid", m0.valid, 1'b0);
    check("rst_mem_we", m0.we, 1'b0);
    check("rst_state", 32'(st0), 32'(IDLE));
    @(posedge clk); #1 rst = 1'b0;

    // aligned word load at 0x100
    mb[8'h00] = 8'hF0; mb[8'h01] = 8'h00; mb[8'h02] = 8'h00; mb[8'h03] = 8'h80;
    run_req(1'b0, 1'b0, 32'h0000_0100, MEM_WORD, 1'b0, 32'h0, n, lat, rdata, err);
    check("lw_lat", lat, 2);
    check("lw_rdata", rdata, 32'h8000_00F0);
    check("lw_err", err, 1'b0);
    exp_a.push_back(32'h100); exp_q.push_back(32'h0);
    check_log("lw", n, 1'b0, MEM_WORD);

    // signed and unsigned byte load at 0x103 with non-zero neighbours
    mb[8'h03] = 8'h80; mb[8'h04] = 8'h5A; mb[8'h05] = 8'hA5; mb[8'h06] = 8'h5A;
    run_req(1'b0, 1'b0, 32'h0000_0103, MEM_BYTE, 1'b0, 32'h0, n, lat, rdata, err);
    check("lb_lat", lat, 2);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    run_req(1'b0, 1'b0, 32'h0000_0103, MEM_BYTE, 1'b1, 32'h0, n, lat, rdata, err);
    check("lbu_rdata", rdata, 32'h0000_0080);

    // aligned signed halfword load at 0x104: 0xA55A
    run_req(1'b0, 1'b0, 32'h0000_0104, MEM_HALF, 1'b0, 32'h0, n, lat, rdata, err);
    check("lh_rdata", rdata, 32'hFFFF_A55A);

    // misaligned word store at 0x101
    for (int i = 0; i < 8; i++) mb[i] = 8'h00;
    run_req(1'b0, 1'b1, 32'h0000_0101, MEM_WORD, 1'b0, 32'hAABB_CCDD, n, lat, rdata, err);
    check("sw_mis_lat", lat, 5);
    check("sw_mis_rdata", rdata, 32'h0);
    exp_a = '{32'h101, 32'h102, 32'h103, 32'h104};
    exp_q = '{32'hDD, 32'hCC, 32'hBB, 32'hAA};
    check_log("sw_mis", n, 1'b1, MEM_BYTE);
    check("sw_mis_mem", {mb[4], mb[3], mb[2], mb[1]}, 32'hAABB_CCDD);
    check("sw_mis_mem0", mb[0], 8'h00);

    // misaligned halfword load wrapping past 0xFFFF_FFFF
    mb[8'hFF] = 8'h34; mb[8'h00] = 8'h12;
    run_req(1'b0, 1'b0, 32'hFFFF_FFFF, MEM_HALF, 1'b0, 32'h0, n, lat, rdata, err);
    check("lh_wrap_lat", lat, 3);
    check("lh_wrap_rdata", rdata, 32'h0000_1234);
    exp_a = '{32'hFFFF_FFFF, 32'h0000_0000};
    check_log("lh_wrap", n, 1'b0, MEM_BYTE);

    // misaligned signed halfword load at 0x201: bytes 0x34, 0x92
    mb[8'h01] = 8'h34; mb[8'h02] = 8'h92;
    run_req(1'b0, 1'b0, 32'h0000_0201, MEM_HALF, 1'b0, 32'h0, n, lat, rdata, err);
    check("lh_mis_s_rdata", rdata, 32'hFFFF_9234);

    // misaligned word load at 0x7: bytes 0x07..0x0A
    mb[8'h07] = 8'h11; mb[8'h08] = 8'h22; mb[8'h09] = 8'h33; mb[8'h0A] = 8'h44;
    run_req(1'b0, 1'b0, 32'h0000_0007, MEM_WORD, 1'b0, 32'h0, n, lat, rdata, err);
    check("lw_mis_lat", lat, 5);
    check("lw_mis_rdata", rdata, 32'h4433_2211);

    // rejecting instance: misaligned word load, then an aligned one
    run_req(1'b1, 1'b0, 32'h0000_0002, MEM_WORD, 1'b0, 32'h0, n, lat, rdata, err);
    check("rej_lat", lat, 1);
    check("rej_err", err, 1'b1);
    check("rej_rdata", rdata, 32'h0);
    check("rej_mem_valid", rej_mem_cnt, 0);
    run_req(1'b1, 1'b0, 32'h0000_0004, MEM_WORD, 1'b0, 32'h0, n, lat, rdata, err);
    check("rej_al_lat", lat, 2);
    check("rej_al_err", err, 1'b0);
    check("rej_al_rdata", rdata, 32'h1234_5678);
    check("rej_al_mem", rej_mem_cnt, 1);

    // reset during a split store, after its second byte
    for (int i = 0; i < 8; i++) mb[i] = 8'h00;
    @(negedge clk);
    clear_log();
    n = cyc;
    sel = 1'b0; req_we = 1'b1; req_addr = 32'h0000_0301; req_width = MEM_WORD;
    req_wdata = 32'h1122_3344; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("abort_mem_valid", m0.valid, 1'b0);
    check("abort_resp_valid", rv0, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_state", 32'(st0), 32'(IDLE));
    check("abort_ready", rdy0, 1'b1);
    check("abort_nacc", log_addr.size(), 2);
    check("abort_mem", {mb[4], mb[3], mb[2], mb[1]}, 32'h0000_3344);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_resp", rv0, 1'b0);
      @(negedge clk);
    end

    // following request completes normally
    mb[8'h04] = 8'hCD; mb[8'h05] = 8'hAB;
    run_req(1'b0, 1'b0, 32'h0000_0304, MEM_HALF, 1'b1, 32'h0, n, lat, rdata, err);
    check("post_lat", lat, 2);
    check("post_rdata", rdata, 32'h0000_ABCD);
    check("we_without_valid", bad_we_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 Parameter: SPLIT_MISALIGNED, 1, 1 = split misaligned accesses into byte accesses; 0 = reject them with resp_error.
REQ-003 Port: clk  input  1  clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: req_valid  input  1  request present.
REQ-006 Port: req_ready  output  1  request accepted when req_valid and req_ready are both high.
REQ-007 Port: req_we  input  1  store (1) or load (0).
REQ-008 Port: req_addr  input  `ADDR_MASK  byte address.
REQ-009 Port: req_width  input  memory_access_width_t  byte, halfword or word.
REQ-010 Port: req_unsigned  input  1  zero-extend (1) or sign-extend (0) the load result.
REQ-011 Port: req_wdata  input  `WORD_MASK  store data, right-justified.
REQ-012 Port: resp_valid  output  1  one-cycle completion pulse for loads and stores.
REQ-013 Port: resp_rdata  output  `WORD_MASK  extended load data; 0 for stores and errors.
REQ-014 Port: resp_error  output  1  misaligned request rejected (SPLIT_MISALIGNED=0 only).
REQ-015 Port: mem  memory_port.datapath  --  downstream memory access.

Function
REQ-016 Memory contract: the memory SHALL return data_rd combinationally in the same cycle that valid is high; sub-word data SHALL be right-justified on data_wr and data_rd, and the upper bits of data_rd SHALL be ignored.
REQ-017 The block SHALL implement an FSM with states IDLE, ACCESS, SPLIT and RESP; req_ready SHALL be 1 only in IDLE and only while rst is low.
REQ-018 Aligned definition: a byte access is always aligned; a halfword access is aligned when addr[0]=0; a word access is aligned when addr[1:0]=0.
REQ-019 In IDLE, an accepted request SHALL be captured into registers, and the FSM SHALL move to ACCESS if the request is aligned, else to SPLIT with cnt=0 if SPLIT_MISALIGNED=1, else to RESP with resp_error set.
REQ-020 ACCESS SHALL last one cycle and SHALL drive: mem.valid=1, we, addr and width taken from the captured request, and data_wr=wdata; read data SHALL be captured, then the FSM SHALL move to RESP.
REQ-021 SPLIT SHALL drive one byte access per cycle with: addr = captured addr + cnt (wrapping modulo 2^ADDR width), width = byte, data_wr = wdata byte cnt, and read byte placed into buffer byte cnt (little-endian).
REQ-022 In SPLIT, cnt SHALL increment each cycle; when cnt = N-1 (N = 2 for halfword, 4 for word), the FSM SHALL move to RESP.
REQ-023 RESP SHALL assert resp_valid for exactly one cycle and then return to IDLE; the consumer SHALL never be back-pressured.
REQ-024 For loads, resp_rdata SHALL be the buffer, sign- or zero-extended from 8, 16 or 32 bits according to width and req_unsigned.
REQ-025 Latency, with acceptance in cycle N: aligned responds at N+2; misaligned halfword at N+3; misaligned word at N+5; rejected request at N+1.
REQ-026 mem.valid SHALL be 0 in IDLE and RESP; mem.we SHALL be 0 whenever mem.valid is 0.
REQ-027 A new request SHALL NOT be accepted in the same cycle that resp_valid is high; the earliest next acceptance is the cycle after RESP.

Reset
REQ-028 While rst is high: the FSM SHALL go to IDLE, cnt=0, resp_valid=0, resp_error=0, resp_rdata=0, mem.valid=0, mem.we=0 and req_ready=0.
REQ-029 Reset asserted mid-SPLIT SHALL abort the split with no response; byte writes already issued SHALL NOT be rolled back.

Structure
REQ-030 A shared package lsu_pkg SHALL hold lsu_state_t and a function that returns the byte count for a memory_access_width_t value; the existing memory_access_width_t enum SHALL be reused.
REQ-031 Sign/zero extension SHALL be a combinational sub-module named lsu_extend.

Verification
REQ-032 Scenario: aligned word load at addr 0x100, memory word 0x8000_00F0 -> mem.valid at N+1 with addr 0x100, width word; resp_rdata 0x8000_00F0 at N+2.
REQ-033 Scenario: signed byte load at 0x103, byte 0x80 -> resp_rdata 0xFFFF_FF80; the same load with req_unsigned=1 -> 0x0000_0080.
REQ-034 Scenario: misaligned word store at 0x101, data 0xAABB_CCDD -> byte writes DD@0x101, CC@0x102, BB@0x103, AA@0x104 in cycles N+1..N+4; resp_valid at N+5.
REQ-035 Scenario: misaligned halfword load at 0xFFFF_FFFF, bytes 0x34@0xFFFF_FFFF and 0x12@0x0 -> address wraps to 0x0; resp_rdata 0x0000_1234 at N+3.
REQ-036 Scenario: with SPLIT_MISALIGNED=0, a word load at 0x2 -> no mem.valid; resp_valid=1 and resp_error=1 at N+1.
REQ-037 Scenario: rst asserted after the second byte of a split store -> next cycle mem.valid=0 and state IDLE, no resp_valid; the following request completes normally.
